reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised, scoreboarded register file; next generation of the CPU's 8x8 register file.
//  Two registered read ports, one synchronous write port, plus a per-register busy (scoreboard) bit.
//  The issue logic reserves a destination register, and the later write-back clears it.
//  Sits between decode (reads/reserve) and write-back (write); the control unit stalls on busy/RES_STALL.
// PARAMETERS
//  DATA_W    8  register width in bits
//  ADDR_W    3  address width; depth = 2**ADDR_W registers
//  ZERO_REG  0  1 = register 0 reads as zero, ignores writes, is never busy
// PORTS
//  CLK          in   1       clock; all state updates on posedge
//  RESET        in   1       synchronous, active-high reset
//  IN           in   DATA_W  write data
//  INADDRESS    in   ADDR_W  write address
//  WRITE        in   1       write enable; also clears busy[INADDRESS]
//  RESERVE      in   1       request to mark RESADDRESS busy
//  RESADDRESS   in   ADDR_W  register to reserve
//  RES_STALL    out  1       combinational; reserve refused this cycle
//  OUT1ADDRESS  in   ADDR_W  read port 1 address
//  OUT2ADDRESS  in   ADDR_W  read port 2 address
//  OUT1         out  DATA_W  read port 1 data (registered)
//  OUT2         out  DATA_W  read port 2 data (registered)
//  OUT1_BUSY    out  1       busy bit of the port 1 register (registered)
//  OUT2_BUSY    out  1       busy bit of the port 2 register (registered)
// BEHAVIOUR
//  - Reset:
//    - RESET high at a posedge: all registers 0, all busy bits 0, OUT1/OUT2 0, OUT1_BUSY/OUT2_BUSY 0.
//    - RESET dominates WRITE and RESERVE in that cycle.
//    - Reset mid-reservation discards all pending reservations.
//  - Write: WRITE=1 at a posedge stores IN into reg[INADDRESS] and clears busy[INADDRESS].
//    - Writing a non-busy register is legal; its busy bit stays 0.
//  - Reserve:
//    - RES_STALL = RESERVE & busy[RESADDRESS] & ~(WRITE & INADDRESS==RESADDRESS).
//    - If RESERVE & ~RES_STALL at a posedge, busy[RESADDRESS] <= 1.
//    - Same-cycle WRITE and RESERVE to the same address: data written and busy ends at 1 (reserve wins).
//    - RES_STALL is 0 whenever RESERVE=0.
//  - Read:
//    - Latency is 1 cycle: OUTn/OUTn_BUSY at posedge k+1 reflect OUTnADDRESS sampled at posedge k.
//    - Both ports are independent; they may read the same address.
//  - ZERO_REG=1:
//    - Writes to address 0 are dropped.
//    - Reserves of address 0 never set busy and never stall.
//    - Reads of address 0 return 0 and busy 0.
//  - No # delays in RTL. No latches. Single always_ff for state.
// CONFIGURATION
//  REG_FILE_SB_BYPASS_EN defined:
//    - A read sampled in the same cycle as a write/reserve sees the post-edge state.
//    - It returns IN (and the updated busy bit) when OUTnADDRESS == INADDRESS.
//  Not defined:
//    - Reads sample pre-edge state; the new value is visible one cycle later.
//    - RES_STALL is identical in both builds.
// STRUCTURE
//  - Package reg_file_sb_pkg: default DATA_W/ADDR_W localparams, typedef data_t, typedef addr_t,
//    and a function next_busy() shared by the file and its read ports.
//  - Sub-module reg_file_sb_rdport: one registered read port (addr -> data, busy, bypass mux).
//    It is instantiated twice.
//  - The storage array and the busy vector stay in the top module.
// TESTING
//  1. RESET=1 one cycle, then read all 8 addresses on both ports -> OUT=0, BUSY=0 everywhere.
//  2. WRITE reg1=82; next cycle read reg1 on port1 -> OUT1=82 one cycle after address applied.
//     With REG_FILE_SB_BYPASS_EN, reading reg1 in the write cycle gives 82 at the next edge.
//  3. RESERVE reg3 -> OUT1_BUSY=1 for reg3.
//     RESERVE reg3 again -> RES_STALL=1 and busy unchanged.
//     WRITE reg3=35 -> busy cleared, OUT1=35.
//  4. Same cycle WRITE reg3=70 and RESERVE reg3 while busy -> RES_STALL=0, reg3=70, busy stays 1.
//  5. ZERO_REG=1: WRITE reg0=22, RESERVE reg0 -> OUT1=0, OUT1_BUSY=0, RES_STALL=0.
//  6. Reserve reg2 and reg5, assert RESET mid-sequence with WRITE=1 to reg2=50.
//     Expect all busy 0, reg2=0, outputs 0 after reset.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared types and busy-bit update rule for the scoreboarded register file.
// Used by reg_file_sb and reg_file_sb_rdport.
package reg_file_sb_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 3;

  typedef logic [DefDataW-1:0] data_t;
  typedef logic [DefAddrW-1:0] addr_t;

  // A reserve landing in the same cycle as the write-back wins.
  function automatic logic next_busy(logic cur, logic wr_hit, logic res_hit);
    return res_hit | (cur & ~wr_hit);
  endfunction

endpackage

// File: rtl/reg_file_sb_rdport.sv
// One registered read port of reg_file_sb: returns data and busy one cycle after the address.
// With REG_FILE_SB_BYPASS_EN defined, a same-cycle write/reserve is forwarded to the read.
module reg_file_sb_rdport
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_busy_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              res_en_i,
  input  logic [ADDR_W-1:0] res_addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              busy_d, busy_q;

  always_comb begin
`ifdef REG_FILE_SB_BYPASS_EN
    data_d = (wr_en_i && (wr_addr_i == addr_i)) ? wr_data_i : rd_data_i;
    busy_d = next_busy(rd_busy_i, wr_en_i && (wr_addr_i == addr_i),
                       res_en_i && (res_addr_i == addr_i));
`else
    data_d = rd_data_i;
    busy_d = rd_busy_i;
`endif
    if (ZERO_REG && (addr_i == '0)) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

`ifndef REG_FILE_SB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i, res_en_i, res_addr_i};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: two registered read ports, one write port, per-register busy bit.
// Optional build macro REG_FILE_SB_BYPASS_EN forwards same-cycle updates to the read ports.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] RESADDRESS,
  output logic              RES_STALL,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1_BUSY,
  output logic              OUT2_BUSY
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [Depth-1:0]             busy_q, busy_d;
  logic                         wr_en, res_en;

  always_comb begin
    // A write-back to the same register in this cycle frees it in time for the reserve.
    RES_STALL = RESERVE & busy_q[RESADDRESS] & ~(WRITE & (INADDRESS == RESADDRESS));
    wr_en     = WRITE & ~(ZERO_REG && (INADDRESS == '0));
    res_en    = RESERVE & ~RES_STALL & ~(ZERO_REG && (RESADDRESS == '0));

    regs_d = regs_q;
    if (wr_en) begin
      regs_d[INADDRESS] = IN;
    end
    for (int unsigned i = 0; i < Depth; i++) begin
      busy_d[i] = next_busy(busy_q[i], wr_en && (INADDRESS == ADDR_W'(i)),
                            res_en && (RESADDRESS == ADDR_W'(i)));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  reg_file_sb_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rdport1 (
    .clk_i      (CLK),
    .reset_i    (RESET),
    .addr_i     (OUT1ADDRESS),
    .rd_data_i  (regs_q[OUT1ADDRESS]),
    .rd_busy_i  (busy_q[OUT1ADDRESS]),
    .wr_en_i    (wr_en),
    .wr_addr_i  (INADDRESS),
    .wr_data_i  (IN),
    .res_en_i   (res_en),
    .res_addr_i (RESADDRESS),
    .data_o     (OUT1),
    .busy_o     (OUT1_BUSY)
  );

  reg_file_sb_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rdport2 (
    .clk_i      (CLK),
    .reset_i    (RESET),
    .addr_i     (OUT2ADDRESS),
    .rd_data_i  (regs_q[OUT2ADDRESS]),
    .rd_busy_i  (busy_q[OUT2ADDRESS]),
    .wr_en_i    (wr_en),
    .wr_addr_i  (INADDRESS),
    .wr_data_i  (IN),
    .res_en_i   (res_en),
    .res_addr_i (RESADDRESS),
    .data_o     (OUT2),
    .busy_o     (OUT2_BUSY)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a plain instance and a ZERO_REG instance share one stimulus.
// Expected read results are queued at issue time and checked by a separate monitor.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam int unsigned Depth = 2 ** DefAddrW;

  logic  CLK;
  logic  RESET, WRITE, RESERVE;
  data_t IN;
  addr_t INADDRESS, RESADDRESS, OUT1ADDRESS, OUT2ADDRESS;

  data_t out1 [2];
  data_t out2 [2];
  logic  out1_busy [2];
  logic  out2_busy [2];
  logic  res_stall [2];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  reg_file_sb #(.DATA_W(DefDataW), .ADDR_W(DefAddrW), .ZERO_REG(1'b0)) u_dut_plain (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_STALL(res_stall[0]),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1[0]), .OUT2(out2[0]),
    .OUT1_BUSY(out1_busy[0]), .OUT2_BUSY(out2_busy[0])
  );

  reg_file_sb #(.DATA_W(DefDataW), .ADDR_W(DefAddrW), .ZERO_REG(1'b1)) u_dut_zero (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_STALL(res_stall[1]),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1[1]), .OUT2(out2[1]),
    .OUT1_BUSY(out1_busy[1]), .OUT2_BUSY(out2_busy[1])
  );

  typedef struct packed {
    data_t o1;
    data_t o2;
    logic  b1;
    logic  b2;
  } rd_t;

  typedef struct packed {
    rd_t p;
    rd_t z;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference state: register contents and reservation flags per instance.
  data_t mem [2][Depth];
  logic  bsy [2][Depth];

  task automatic chk(input string name, input int inst, input data_t act, input data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rst, input logic we, input addr_t wa, input data_t wd,
                     input logic re, input addr_t ra, input addr_t a1, input addr_t a2);
    rd_t   r [2];
    logic  stall [2];
    item_t it;
    @(negedge CLK);
    RESET = rst; WRITE = we; INADDRESS = wa; IN = wd;
    RESERVE = re; RESADDRESS = ra; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    for (int j = 0; j < 2; j++) begin
      data_t nmem [Depth];
      logic  nbsy [Depth];
      bit    zr;
      zr = (j == 1);
      stall[j] = re && bsy[j][ra] && !(we && (wa == ra));
      for (int k = 0; k < Depth; k++) begin
        nmem[k] = rst ? '0 : mem[j][k];
        nbsy[k] = rst ? 1'b0 : bsy[j][k];
      end
      if (!rst) begin
        if (we && !(zr && wa == '0)) begin
          nmem[wa] = wd;
          nbsy[wa] = 1'b0;
        end
        if (re && !stall[j] && !(zr && ra == '0)) nbsy[ra] = 1'b1;
      end
`ifdef REG_FILE_SB_BYPASS_EN
      r[j].o1 = nmem[a1]; r[j].b1 = nbsy[a1];
      r[j].o2 = nmem[a2]; r[j].b2 = nbsy[a2];
`else
      r[j].o1 = mem[j][a1]; r[j].b1 = bsy[j][a1];
      r[j].o2 = mem[j][a2]; r[j].b2 = bsy[j][a2];
`endif
      if (rst) r[j] = '0;
      if (zr && a1 == '0) begin r[j].o1 = '0; r[j].b1 = 1'b0; end
      if (zr && a2 == '0) begin r[j].o2 = '0; r[j].b2 = 1'b0; end
      for (int k = 0; k < Depth; k++) begin
        mem[j][k] = nmem[k];
        bsy[j][k] = nbsy[k];
      end
    end
    it.p = r[0];
    it.z = r[1];
    exp_q.push_back(it);
    #1;
    for (int j = 0; j < 2; j++) chk("res_stall", j, data_t'(res_stall[j]), data_t'(stall[j]));
  endtask

  // Monitor: the registered outputs of each edge are checked against the queued expectation.
  initial begin
    item_t m_it;
    rd_t   e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        m_it = exp_q.pop_front();
        for (int j = 0; j < 2; j++) begin
          e = (j == 1) ? m_it.z : m_it.p;
          chk("out1", j, out1[j], e.o1);
          chk("out2", j, out2[j], e.o2);
          chk("out1_busy", j, data_t'(out1_busy[j]), data_t'(e.b1));
          chk("out2_busy", j, data_t'(out2_busy[j]), data_t'(e.b2));
        end
      end
    end
  end

  initial begin
    RESET = 1'b1; WRITE = 1'b0; RESERVE = 1'b0; IN = '0;
    INADDRESS = '0; RESADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < Depth; k++) begin
        mem[j][k] = '0;
        bsy[j][k] = 1'b0;
      end

    // Reset, then sweep all addresses on both ports.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < Depth; a++) cyc(0, 0, 0, 0, 0, 0, addr_t'(a), addr_t'(Depth - 1 - a));

    // Write then read back, including a read in the write cycle.
    cyc(0, 1, 1, 82, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 2);

    // Reserve, stalled re-reserve, write-back clears busy.
    cyc(0, 0, 0, 0, 1, 3, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3);
    cyc(0, 0, 0, 0, 1, 3, 3, 3);
    cyc(0, 1, 3, 35, 0, 0, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3);

    // Same-cycle write and reserve of a busy register: reserve wins.
    cyc(0, 0, 0, 0, 1, 3, 3, 3);
    cyc(0, 1, 3, 70, 1, 3, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3);

    // Register 0 write/reserve (dropped only on the ZERO_REG instance).
    cyc(0, 1, 0, 22, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of outstanding reservations, with a competing write.
    cyc(0, 0, 0, 0, 1, 2, 2, 5);
    cyc(0, 0, 0, 0, 1, 5, 2, 5);
    cyc(1, 1, 2, 50, 1, 2, 2, 5);
    cyc(0, 0, 0, 0, 0, 0, 2, 5);
    cyc(0, 0, 0, 0, 0, 0, 2, 5);

    // Randomized traffic on a small address space to force collisions.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
          addr_t'($urandom_range(0, Depth - 1)), data_t'($urandom),
          1'($urandom_range(0, 1)), addr_t'($urandom_range(0, Depth - 1)),
          addr_t'($urandom_range(0, Depth - 1)), addr_t'($urandom_range(0, Depth - 1)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
